div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit divider serving the execute stage of the MIPS pipeline for DIV/DIVU. It latches two register operands on a start request and runs one quotient bit per cycle. It holds the pipeline through `busy` while it works. On completion it delivers a one-cycle `hilo_t` write (hi = remainder, lo = quotient) that flows down the pipeline to the HI/LO register.

## Interface

Parameters:
- `WIDTH`, default 32. Operand width. It must equal the width of `reg_data_t`, and no other value is supported.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high (`RST_ENABLE`).
- `start`  in  1  Divide request from the execute stage.
- `is_signed`  in  1  1 = DIV, 0 = DIVU. Sampled with `start`.
- `dividend`  in  32  (`reg_data_t`) Sampled with `start`.
- `divisor`  in  32  (`reg_data_t`) Sampled with `start`.
- `cancel`  in  1  Flush from a taken jump or exception. Aborts any operation.
- `busy`  out  1  Stall request to the pipeline.
- `done`  out  1  One-cycle completion pulse.
- `result`  out  `hilo_t`  `en` = `REG_ENABLE` only while `done`=1; `hi` = remainder, `lo` = quotient.

## Operation

- States: IDLE, BYZERO, ON, END.
- IDLE:
  - If `start`=1 and `cancel`=0: latch `is_signed`, |dividend|, |divisor| and both sign bits.
  - Magnitudes use two's-complement negation only when `is_signed`=1 and the operand MSB=1.
  - Next state is BYZERO if `divisor`==0, otherwise ON with iteration counter = 0.
- ON: restoring radix-2 step per cycle.
  - Shift the 64-bit {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from the upper 33 bits.
  - On no borrow, keep the difference and set the new quotient LSB to 1.
  - After the 32nd step (counter==31), go to END.
- Sign fix in END (signed only):
  - Quotient negated if the dividend sign differs from the divisor sign.
  - Remainder negated if the dividend was negative.
- Overflow case: 0x80000000 / 0xFFFFFFFF (signed) yields lo=0x80000000, hi=0. The natural result of the magnitude path is kept; no trap.
- BYZERO: one cycle, then END with lo=0xFFFFFFFF and hi=original `dividend`, regardless of `is_signed`.
- END: `done`=1 and `result.en`=`REG_ENABLE` for this cycle only. Next state is always IDLE.
- `start` outside IDLE is ignored. Operand or `is_signed` changes after acceptance are ignored.
- `cancel`=1 in any state forces IDLE at the next edge. In END, `cancel`=1 suppresses `done` and `result.en` in the same cycle.
- `busy` = (state ∈ {ON, BYZERO}) OR (state==IDLE AND `start` AND NOT `cancel`). This is combinational, so the requesting instruction stalls in its issue cycle. `busy`=0 in END, which lets the execute stage advance while consuming the result.

## Timing

- Reset (`rst`=1 at an edge): state IDLE, counter 0, `done`=0, `result.en`=`REG_DISABLE`, `result.hi`=`result.lo`=0. `busy`=0 whenever `start`=0. `rst` overrides `start` and `cancel`, including mid-operation.
- Non-zero divisor: `start` accepted in cycle 0, ON in cycles 1–32, END with `done`=1 in cycle 33. Latency is 33 cycles.
- Zero divisor: BYZERO in cycle 1, END with `done` in cycle 2.
- Back-to-back operations: END→IDLE is mandatory. The earliest next acceptance is the cycle after `done` (cycle 34).
- `result.hi`/`lo` hold their last value between operations; only `result.en` qualifies them.
- `cancel` in cycle k (1 ≤ k ≤ 33): state is IDLE in cycle k+1, no `done` pulse, and a new `start` in cycle k+1 is accepted normally.

## Test plan

- DIVU 100 / 7, `start` in cycle 0 → `busy`=1 in cycles 0–32; `done`=1 only in cycle 33 with lo=14, hi=2, `en`=`REG_ENABLE`.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands → lo=0x7FFFFFFC, hi=1.
- DIV 0x00001234 / 0 → `done` in cycle 2 with lo=0xFFFFFFFF, hi=0x00001234; `busy` low from cycle 2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- Two aborted runs:
  - `cancel` in cycle 10 → no `done`, `busy`=0 in cycle 11, then DIVU 9/3 started in cycle 11 completes in cycle 44 with lo=3, hi=0.
  - `rst` in cycle 20 → all outputs at reset values in cycle 21.
- Ignored inputs: change `dividend`, `divisor` and `is_signed` and pulse `start` during cycles 1–32 → the result still matches the operands latched in cycle 0, with exactly one `done` pulse.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider for MIPS DIV/DIVU.
// Produces one quotient bit per cycle and emits {hi=remainder, lo=quotient} as a one-cycle HI/LO write.
package div_pkg;
  typedef logic [31:0] reg_data_t;
  typedef struct packed {
    logic      en;
    reg_data_t hi;
    reg_data_t lo;
  } hilo_t;
  localparam logic RST_ENABLE  = 1'b1;
  localparam logic REG_ENABLE  = 1'b1;
  localparam logic REG_DISABLE = 1'b0;
endpackage

module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      is_signed,
  input  reg_data_t dividend,
  input  reg_data_t divisor,
  input  logic      cancel,
  output logic      busy,
  output logic      done,
  output hilo_t     result
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH+1:0]   w_sub;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;

  assign w_accept = (r_state == S_IDLE) && start && !cancel;
  assign w_a_neg  = is_signed & dividend[WIDTH-1];
  assign w_b_neg  = is_signed & divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -dividend : dividend;
  assign w_b_mag  = w_b_neg ? -divisor  : divisor;

  // Trial subtraction on the shifted partial remainder; both top bits are set on a borrow.
  assign w_sub    = {1'b0, r_rem, r_quo[WIDTH-1]} - {2'b00, r_dvs};
  assign w_borrow = |w_sub[WIDTH+1:WIDTH];
  assign w_rem_nx = w_borrow ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_sub[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], !w_borrow};

  assign busy      = (r_state == S_ON) || (r_state == S_BYZERO) || w_accept;
  assign done      = (r_state == S_END) && !cancel;
  assign result.en = done ? REG_ENABLE : REG_DISABLE;
  assign result.hi = r_hi;
  assign result.lo = r_lo;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (cancel) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            // A zero divisor keeps the raw dividend so it can be returned as hi.
            if (divisor == '0) begin
              r_quo   <= dividend;
              r_state <= S_BYZERO;
            end else begin
              r_quo   <= w_a_mag;
              r_state <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          r_hi    <= r_quo;
          r_lo    <= '1;
          r_state <= S_END;
        end
        S_ON: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_lo    <= r_neg_q ? -w_quo_nx : w_quo_nx;
            r_hi    <= r_neg_r ? -w_rem_nx : w_rem_nx;
            r_state <= S_END;
          end
        end
        S_END:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
